// File: rtl/acc_word_memory.sv
// acc_word_memory: 32x16 synchronous data memory beside the accumulator datapath,
// self-initialised with an arithmetic pattern after every reset.
module acc_word_memory #(
   parameter logic [15:0] INIT_BASE = 16'h0001,
   parameter logic [15:0] INIT_STEP = 16'h0001
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [4:0]  Address,
   input  logic [15:0] DataIN,
   input  logic        ReadEnable,
   input  logic        WriteEnable,
   output logic [15:0] DataOut,
   output logic        InitDone,
   output logic        AccessDropped
);
   typedef enum logic {INIT, SERVE} state_t;
   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] word_q, word_d;
   logic [15:0] data_q, data_d;
   logic        dropped_q, dropped_d;
   logic [15:0] mem [32];
   logic        we;
   logic [4:0]  waddr;
   logic [15:0] wdata;
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= INIT;
         cnt_q     <= '0;
         word_q    <= INIT_BASE;
         data_q    <= '0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         word_q    <= word_d;
         data_q    <= data_d;
         dropped_q <= dropped_d;
      end
   end
   // Running sum replaces INIT_BASE + cnt*INIT_STEP; wraps naturally at 16 bits.
   always_comb begin
      state_d   = (state_q == INIT && cnt_q == 5'd31) ? SERVE : state_q;
      cnt_d     = (state_q == INIT) ? cnt_q + 5'd1 : cnt_q;
      word_d    = (state_q == INIT) ? word_q + INIT_STEP : word_q;
      data_d    = (state_q == SERVE && ReadEnable) ? mem[Address] : data_q;
      dropped_d = dropped_q | (state_q == INIT && (ReadEnable || WriteEnable));
      we        = (state_q == INIT) | WriteEnable;
      waddr     = (state_q == INIT) ? cnt_q : Address;
      wdata     = (state_q == INIT) ? word_q : DataIN;
   end
   always_ff @(posedge Clock)
      if (we) mem[waddr] <= wdata;
   assign DataOut       = data_q;
   assign InitDone      = (state_q == SERVE);
   assign AccessDropped = dropped_q;
endmodule
